// File: rtl/gmii_rx.sv
// GMII receive framer: strips preamble/SFD, checks FCS and length,
// and pushes frame bytes plus one status word per frame into a FIFO.
module gmii_rx #(
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 1522
) (
   input  logic        phy_rx_clk,
   input  logic        sys_rst_n,
   input  logic        phy_rx_dv,
   input  logic        phy_rx_er,
   input  logic [7:0]  phy_rxd,
   input  logic        wr_full,
   output logic        wr_en,
   output logic [8:0]  wr_data,
   output logic [15:0] frame_ok_cnt,
   output logic [15:0] frame_err_cnt
);

   typedef enum logic [2:0] {
      IDLE,
      PREAMBLE,
      DATA,
      TERM,
      DROP
   } state_t;

   localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
   localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
   // residue written MSB-first; register holds it bit-reversed
   localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
   localparam logic [12:0] CNT_MAX     = 13'h1FFF;
   localparam logic [12:0] MIN_L       = 13'(MIN_LEN);
   localparam logic [12:0] MAX_L       = 13'(MAX_LEN);
   localparam logic [7:0]  PRE_BYTE    = 8'h55;
   localparam logic [7:0]  SFD_BYTE    = 8'hD5;

   function automatic logic [31:0] crc_byte(
      input logic [31:0] c,
      input logic [7:0]  d
   );
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         if (r[0] ^ d[i]) r = (r >> 1) ^ CRC_POLY;
         else             r = r >> 1;
      end
      return r;
   endfunction

   function automatic logic [31:0] bitrev(input logic [31:0] c);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = c[31-i];
      return r;
   endfunction

   state_t      state;
   logic        dv_q;
   logic        er_q;
   logic [7:0]  rxd_q;
   logic [12:0] cnt;
   logic [31:0] crc;
   logic        crc_ok;
   logic        er_flag;
   logic        ovf;
   logic        runt;
   logic        giant;
   logic        good;
   logic [8:0]  status;

   assign runt   = cnt < MIN_L;
   assign giant  = cnt > MAX_L;
   assign good   = crc_ok & ~runt & ~giant & ~er_flag & ~ovf;
   assign status = {1'b0, 3'b000, giant, runt, ovf, er_flag, crc_ok};

   // register the GMII inputs; all decisions use these copies
   always_ff @(posedge phy_rx_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         dv_q  <= 1'b0;
         er_q  <= 1'b0;
         rxd_q <= 8'h00;
      end else begin
         dv_q  <= phy_rx_dv;
         er_q  <= phy_rx_er;
         rxd_q <= phy_rxd;
      end
   end

   // framing FSM with registered FIFO write, CRC, length and flags
   always_ff @(posedge phy_rx_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state         <= IDLE;
         wr_en         <= 1'b0;
         wr_data       <= 9'h000;
         frame_ok_cnt  <= 16'h0000;
         frame_err_cnt <= 16'h0000;
         cnt           <= 13'h0000;
         crc           <= CRC_INIT;
         crc_ok        <= 1'b0;
         er_flag       <= 1'b0;
         ovf           <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         case (state)
            IDLE, PREAMBLE: begin
               if (!dv_q) begin
                  state <= IDLE;
               end else if (rxd_q == PRE_BYTE) begin
                  state <= PREAMBLE;
               end else if (rxd_q == SFD_BYTE) begin
                  state   <= DATA;
                  cnt     <= 13'h0000;
                  crc     <= CRC_INIT;
                  crc_ok  <= 1'b0;
                  er_flag <= 1'b0;
                  ovf     <= 1'b0;
               end else begin
                  state <= DROP;
               end
            end
            DATA: begin
               if (dv_q) begin
                  er_flag <= er_flag | er_q;
                  crc     <= crc_byte(crc, rxd_q);
                  if (cnt != CNT_MAX) cnt <= cnt + 13'd1;
                  if (wr_full) begin
                     ovf <= 1'b1;
                  end else begin
                     wr_en   <= 1'b1;
                     wr_data <= {1'b1, rxd_q};
                  end
               end else begin
                  state  <= TERM;
                  crc_ok <= (bitrev(crc) == CRC_RESIDUE);
               end
            end
            TERM: begin
               if (!wr_full) begin
                  wr_en   <= 1'b1;
                  wr_data <= status;
                  if (good) frame_ok_cnt  <= frame_ok_cnt + 16'd1;
                  else      frame_err_cnt <= frame_err_cnt + 16'd1;
                  state <= dv_q ? DROP : IDLE;
               end
            end
            DROP: begin
               if (!dv_q) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/gmii_rx.md
GMII_RX -- requirements
Module: gmii_rx

Interface
REQ-001 SHALL have parameter MIN_LEN, default 64: minimum frame length in bytes, counted SFD-exclusive and FCS-inclusive.
REQ-002 SHALL have parameter MAX_LEN, default 1522: maximum frame length in bytes, counted the same way.
REQ-003 SHALL have port phy_rx_clk  input  1  single clock; every register in the block is clocked on its rising edge.
REQ-004 SHALL have port sys_rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port phy_rx_dv  input  1  GMII receive data valid.
REQ-006 SHALL have port phy_rx_er  input  1  GMII receive error.
REQ-007 SHALL have port phy_rxd  input  8  GMII receive data.
REQ-008 SHALL have port wr_full  input  1  downstream FIFO full; no write is accepted while it is high.
REQ-009 SHALL have port wr_en  output  1  write strobe to the downstream FIFO.
REQ-010 SHALL have port wr_data  output  9  FIFO word: bit 8 = 1 for a frame byte, bit 8 = 0 for an end-of-frame status word.
REQ-011 SHALL have port frame_ok_cnt  output  16  count of good frames, wrapping.
REQ-012 SHALL have port frame_err_cnt  output  16  count of bad frames, wrapping.

Function
REQ-013 SHALL register phy_rx_dv, phy_rx_er and phy_rxd on every clock edge; all decisions below use the registered copies.
REQ-014 SHALL implement the states IDLE, PREAMBLE, DATA, TERM and DROP.
REQ-015 IDLE: dv=1 with rxd=0x55 -> PREAMBLE; dv=1 with rxd=0xD5 -> DATA; dv=1 with any other byte -> DROP.
REQ-016 PREAMBLE: rxd=0x55 -> stay; rxd=0xD5 -> DATA; any other byte with dv=1 -> DROP; dv=0 -> IDLE; no FIFO write occurs in this state.
REQ-017 DATA: each byte with dv=1 SHALL be written as {1'b1, rxd}, with wr_en high exactly one cycle after the registered sample.
REQ-018 DATA: the byte counter (13 bits, saturating at 8191) SHALL increment once per received byte.
REQ-019 DATA: the CRC-32 SHALL be updated once per received byte.
REQ-020 DATA: dv falling to 0 -> TERM.
REQ-021 CRC-32 SHALL use the 802.3 polynomial, reflected, processing bit 0 of each byte first.
REQ-022 CRC-32 SHALL be initialised to 0xFFFFFFFF on entry to DATA.
REQ-023 crc_ok SHALL be set iff the CRC register equals residue 0xC704DD7B at the DATA->TERM transition.
REQ-024 TERM SHALL write the status word {1'b0, 3'b0, giant, runt, ovf, er, crc_ok}.
REQ-025 Status flag runt SHALL be set iff count < MIN_LEN.
REQ-026 Status flag giant SHALL be set iff count > MAX_LEN.
REQ-027 Status flag er SHALL be set iff phy_rx_er was high on any DATA cycle.
REQ-028 Status flag ovf SHALL be set iff any frame byte was dropped because wr_full was high.
REQ-029 TERM: the status word SHALL be held until wr_full=0, then written in one cycle; dv activity during TERM SHALL be ignored.
REQ-030 TERM exit SHALL go to IDLE if dv=0, otherwise to DROP.
REQ-031 DROP SHALL write nothing and SHALL return to IDLE when dv=0.
REQ-032 DATA with wr_full=1: the byte SHALL be discarded, ovf SHALL be set, and wr_en SHALL stay low.
REQ-033 A frame is good iff crc_ok=1 and runt=giant=er=ovf=0.
REQ-034 frame_ok_cnt or frame_err_cnt SHALL increment in the cycle the status word is written; both counters wrap from 0xFFFF to 0x0000.
REQ-035 An entry to DROP from IDLE or PREAMBLE SHALL NOT change either counter.
REQ-036 wr_en SHALL never be high for two words of different frames within one cycle; at most one write per cycle.
REQ-037 A frame whose SFD is followed immediately by dv=0 (0 data bytes) SHALL produce only a status word with runt=1 and crc_ok=0.

Reset
REQ-038 sys_rst_n=0 SHALL asynchronously force state=IDLE, wr_en=0, wr_data=0, frame_ok_cnt=0, frame_err_cnt=0, byte counter=0, all flags=0 and the input registers to 0.
REQ-039 Reset asserted mid-frame SHALL abandon the frame with no status word.
REQ-040 After reset release with dv already high, the block SHALL enter DROP unless the first sampled byte is 0x55 or 0xD5.

Verification
REQ-041 Bench SHALL cover: 7x0x55, 0xD5, then 60-byte payload plus valid FCS (64 bytes) -> 64 writes of {1,byte}, then status 0x001, frame_ok_cnt=1.
REQ-042 Bench SHALL cover: the same frame with one payload bit flipped -> 64 data writes, then status 0x000, frame_err_cnt=1.
REQ-043 Bench SHALL cover: a 40-byte frame with valid FCS -> status 0x009 (runt, crc_ok), frame_err_cnt increments.
REQ-044 Bench SHALL cover: wr_full=1 for bytes 10..12 and again at end of frame for 5 cycles -> 61 data writes, status 0x005 written after wr_full drops, and a new frame starting during TERM is dropped.
REQ-045 Bench SHALL cover: phy_rx_er high on byte 20 -> status bit 1 set; a preamble broken by 0x00 -> DROP, no writes, counters unchanged.
REQ-046 Bench SHALL cover: sys_rst_n pulsed low at byte 30 -> wr_en=0 immediately; the next clean frame yields frame_ok_cnt=1.
